// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared opcode constants, control-field encodings, FSM state type and control word for the
// multicycle MIPS controller. Optional ILLEGAL_TRAP_EN changes only the top and decoder.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_IMM} alu_op_e;
    typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_EXC} pc_src_e;
    typedef enum logic [1:0] {MTR_ALUOUT, MTR_MDR, MTR_PC} mem_to_reg_e;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} reg_dst_e;
    typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH} alu_src_b_e;

    // Shared by the state register in the top and the output decoder.
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MADDR, S_MREAD, S_MWB, S_MWRITE, S_EXEC,
        S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_TRAP, S_ERROR
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_IMM, CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic        pc_en;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        reg_dst_e    reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        reg_write;
        logic        alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        pc_src_e     pc_source;
        logic        instr_done;
    } ctrl_t;

    function automatic op_class_e classify(input logic [5:0] op);
        case (op)
            OP_R_TYPE:                     return CLS_R;
            OP_LW, OP_SW:                  return CLS_MEM;
            OP_BEQ, OP_BNE:                return CLS_BRANCH;
            OP_J:                          return CLS_JUMP;
            OP_JAL:                        return CLS_JAL;
            OP_ADDI, OP_ADDIU, OP_ORI,
            OP_LUI:                        return CLS_IMM;
            default:                       return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_out_decode.sv
// Combinational control-word decode from FSM state, opcode, zero and mem_ready.
// ILLEGAL_TRAP_EN: illegal opcodes retire through TRAP instead of as a NOP in DECODE.
module mips_mc_out_decode
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_e              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output ctrl_t               ctrl
);

    logic [5:0] op;

    assign op = 6'(opcode);

    always_comb begin
        // NOTE: default the whole word first so no branch leaves a field unassigned (no latches).
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
`ifdef ILLEGAL_TRAP_EN
                ctrl.instr_done = 1'b0;
`else
                ctrl.instr_done = (classify(op) == CLS_ILLEGAL);
`endif
            end
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MWB: begin
                ctrl.mem_to_reg = MTR_MDR;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MWRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_dst    = DST_RD;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op == OP_ORI || op == OP_LUI) ? ALU_IMM : ALU_ADD;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                // BNE inverts the sense of the zero flag for the conditional PC write.
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_source  = PC_ALUOUT;
                ctrl.pc_en      = zero ^ (op == OP_BNE);
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_en      = 1'b1;
                ctrl.pc_source  = PC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_en      = 1'b1;
                ctrl.pc_source  = PC_JUMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RA;
                ctrl.mem_to_reg = MTR_PC;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.pc_en     = 1'b1;
                ctrl.pc_source = PC_EXC;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, memory watchdog, retired-instruction counter
// and sticky error flags. Optional ILLEGAL_TRAP_EN routes illegal opcodes through a TRAP state.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic [CNT_W-1:0]    instr_count,
    output logic                mem_err,
    output logic                illegal_op
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e            state;
    ctrl_t             ctrl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              timeout;
    logic [5:0]        op;

    assign op      = 6'(opcode);
    assign in_wait = (state == S_FETCH) || (state == S_MREAD) || (state == S_MWRITE);
    // mem_ready on the limit cycle still completes the access.
    assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                     (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    mips_mc_out_decode #(.OPCODE_W(OPCODE_W)) u_out_decode (
        .state     (state),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
            mem_err     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here so every register samples pre-edge values.
            wait_cnt <= (in_wait && !mem_ready) ? wait_cnt + WAIT_W'(1) : '0;
            if (ctrl.instr_done) instr_count <= instr_count + CNT_W'(1);

            if (timeout) begin
                state   <= S_ERROR;
                mem_err <= 1'b1;
            end else begin
                case (state)
                    S_IDLE:   state <= S_FETCH;
                    S_FETCH:  if (mem_ready) state <= S_DECODE;
                    S_DECODE: begin
                        case (classify(op))
                            CLS_R:      state <= S_EXEC;
                            CLS_MEM:    state <= S_MADDR;
                            CLS_BRANCH: state <= S_BRANCH;
                            CLS_JUMP:   state <= S_JUMP;
                            CLS_JAL:    state <= S_JAL;
                            CLS_IMM:    state <= S_IEXEC;
                            default: begin
`ifdef ILLEGAL_TRAP_EN
                                state     <= S_TRAP;
                                illegal_q <= 1'b1;
`else
                                state     <= S_FETCH;
`endif
                            end
                        endcase
                    end
                    S_MADDR:  state <= (op == OP_LW) ? S_MREAD : S_MWRITE;
                    S_MREAD:  if (mem_ready) state <= S_MWB;
                    S_MWRITE: if (mem_ready) state <= S_FETCH;
                    S_EXEC:   state <= S_RWB;
                    S_IEXEC:  state <= S_IWB;
                    S_MWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_TRAP:
                              state <= S_FETCH;
                    S_ERROR:  state <= S_ERROR;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table, randomized instruction
// stream against an instruction-level reference model, reset and watchdog sequences.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] RTYPE = 6'h00, JMP = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, ADDIU = 6'h09, ORI = 6'h0D, LUI = 6'h0F;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero, mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic        instr_done, mem_err, illegal_op;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [31:0] instr_count;

    mips_multicycle_ctrl #(.OPCODE_W(6), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .instr_count(instr_count), .mem_err(mem_err),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       instr_done;
    } cw_t;

    typedef struct {
        logic rdy;
        cw_t  cw;
        logic set_err;
        logic set_ill;
    } step_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         cycles;
        cw_t        last;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] count_m;
    logic        err_m, ill_m;
    step_t       trace[$];
    vec_t        vecs[$];
    logic [5:0]  pool[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic cw_t sample();
        cw_t c;
        c.pc_en = pc_en;         c.iord = iord;             c.mem_read = mem_read;
        c.mem_write = mem_write; c.ir_write = ir_write;     c.reg_dst = reg_dst;
        c.mem_to_reg = mem_to_reg; c.reg_write = reg_write; c.alu_src_a = alu_src_a;
        c.alu_src_b = alu_src_b; c.alu_op = alu_op;         c.pc_source = pc_source;
        c.instr_done = instr_done;
        return c;
    endfunction

    // Field order: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write
    //              alu_src_a alu_src_b alu_op pc_source instr_done
    function automatic cw_t mk(input logic pe, io, mr, mwr, irw, input logic [1:0] rd, mtr,
                               input logic rw, asa, input logic [1:0] asb, aop, pcs,
                               input logic dn);
        return {pe, io, mr, mwr, irw, rd, mtr, rw, asa, asb, aop, pcs, dn};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {RTYPE, JMP, JAL, BEQ, BNE, ADDI, ADDIU, ORI, LUI, LW, SW};
    endfunction

    function automatic cw_t fetch_cw(input logic rdy);
        return mk(rdy, 0, 1, 0, rdy, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    endfunction

    task automatic push(input logic rdy, input cw_t cw, input logic se, input logic si);
        step_t s;
        s.rdy = rdy; s.cw = cw; s.set_err = se; s.set_ill = si;
        trace.push_back(s);
    endtask

    // Reference model: expected per-cycle control words for one whole instruction.
    task automatic build(input logic [5:0] op, input logic z, input int fw, input int mw);
        cw_t c;
        trace.delete();
        for (int i = 0; i < fw; i++) push(1'b0, fetch_cw(1'b0), 1'b0, 1'b0);
        push(1'b1, fetch_cw(1'b1), 1'b0, 1'b0);
        c = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        if (!is_legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
            push(rnd_bit(), c, 1'b0, 1'b0);
            push(rnd_bit(), mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b11, 0),
                 1'b0, 1'b1);
`else
            c.instr_done = 1'b1;
            push(rnd_bit(), c, 1'b0, 1'b0);
`endif
            return;
        end
        push(rnd_bit(), c, 1'b0, 1'b0);
        case (op)
            RTYPE: begin
                push(rnd_bit(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 2'b00, 0), 0, 0);
                push(rnd_bit(), mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1), 0, 0);
            end
            LW, SW: begin
                push(rnd_bit(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 2'b00, 0), 0, 0);
                for (int i = 0; i <= mw; i++) begin
                    c = mk(0, 1, op == LW, op == SW, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00,
                           op == SW && i == mw);
                    push(i == mw, c, 1'b0, 1'b0);
                end
                if (op == LW)
                    push(rnd_bit(), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 1), 0, 0);
            end
            BEQ, BNE: begin
                c = mk((op == BNE) ? ~z : z, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 2'b01, 1);
                push(rnd_bit(), c, 1'b0, 1'b0);
            end
            JMP: push(rnd_bit(), mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1), 0, 0);
            JAL: push(rnd_bit(), mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 2'b00, 2'b10, 1), 0, 0);
            default: begin
                c = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10,
                       (op == ORI || op == LUI) ? 2'b11 : 2'b00, 2'b00, 0);
                push(rnd_bit(), c, 1'b0, 1'b0);
                push(rnd_bit(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1), 0, 0);
            end
        endcase
    endtask

    task automatic apply(input logic [5:0] op, input logic z, input int n,
                         output int done_cyc, output cw_t done_cw);
        step_t s;
        cw_t   got;
        done_cyc = 0;
        done_cw  = '0;
        for (int i = 0; i < n; i++) begin
            s = trace[i];
            @(negedge clk);
            opcode = op; zero = z; mem_ready = s.rdy;
            #1;
            if (s.set_err) err_m = 1'b1;
            if (s.set_ill) ill_m = 1'b1;
            got = sample();
            check("ctrl_word", 32'(got), 32'(s.cw));
            check("instr_count", instr_count, count_m);
            check("mem_err", 32'(mem_err), 32'(err_m));
            check("illegal_op", 32'(illegal_op), 32'(ill_m));
            if (got.instr_done && done_cyc == 0) begin
                done_cyc = i + 1;
                done_cw  = got;
            end
            if (s.cw.instr_done) count_m++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready = rnd_bit();
        @(negedge clk);
        #1;
        check("reset_ctrl", 32'(sample()), 32'h0);
        check("reset_count", instr_count, 32'h0);
        check("reset_mem_err", 32'(mem_err), 32'h0);
        check("reset_illegal", 32'(illegal_op), 32'h0);
        reset = 1'b0;
        count_m = '0; err_m = 1'b0; ill_m = 1'b0;
    endtask

    initial begin
        int  dc;
        cw_t dcw;
        logic [5:0] op;
        logic z;
        int fw, mw;

        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        count_m = '0; err_m = 1'b0; ill_m = 1'b0;
        pool = '{RTYPE, JMP, JAL, BEQ, BNE, ADDI, ADDIU, ORI, LUI, LW, SW, 6'h3F, 6'h11, 6'h1C};

        vecs.push_back('{"add",   RTYPE, 0, 0, 0, 4,  mk(0,0,0,0,0, 2'b01,2'b00, 1,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"lw",    LW,    0, 0, 3, 8,  mk(0,0,0,0,0, 2'b00,2'b01, 1,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"sw",    SW,    0, 1, 2, 7,  mk(0,1,0,1,0, 2'b00,2'b00, 0,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"beq_z1", BEQ,  1, 0, 0, 3,  mk(1,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00,2'b01,2'b01, 1)});
        vecs.push_back('{"beq_z0", BEQ,  0, 0, 0, 3,  mk(0,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00,2'b01,2'b01, 1)});
        vecs.push_back('{"bne_z1", BNE,  1, 0, 0, 3,  mk(0,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00,2'b01,2'b01, 1)});
        vecs.push_back('{"bne_z0", BNE,  0, 0, 0, 3,  mk(1,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00,2'b01,2'b01, 1)});
        vecs.push_back('{"j",     JMP,   0, 0, 0, 3,  mk(1,0,0,0,0, 2'b00,2'b00, 0,0, 2'b00,2'b00,2'b10, 1)});
        vecs.push_back('{"jal",   JAL,   0, 0, 0, 3,  mk(1,0,0,0,0, 2'b10,2'b10, 1,0, 2'b00,2'b00,2'b10, 1)});
        vecs.push_back('{"ori",   ORI,   0, 0, 0, 4,  mk(0,0,0,0,0, 2'b00,2'b00, 1,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"lui",   LUI,   0, 3, 0, 7,  mk(0,0,0,0,0, 2'b00,2'b00, 1,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"addi",  ADDI,  0, 2, 0, 6,  mk(0,0,0,0,0, 2'b00,2'b00, 1,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"addiu", ADDIU, 0, 0, 0, 4,  mk(0,0,0,0,0, 2'b00,2'b00, 1,0, 2'b00,2'b00,2'b00, 1)});
        vecs.push_back('{"lw_wd_edge", LW, 0, 15, 15, 35, mk(0,0,0,0,0, 2'b00,2'b01, 1,0, 2'b00,2'b00,2'b00, 1)});
`ifdef ILLEGAL_TRAP_EN
        vecs.push_back('{"illegal", 6'h3F, 0, 0, 0, 0, '0});
`else
        vecs.push_back('{"illegal", 6'h3F, 0, 0, 0, 2, mk(0,0,0,0,0, 2'b00,2'b00, 0,0, 2'b11,2'b00,2'b00, 1)});
`endif

        do_reset();

        foreach (vecs[i]) begin
            build(vecs[i].op, vecs[i].z, vecs[i].fw, vecs[i].mw);
            apply(vecs[i].op, vecs[i].z, trace.size(), dc, dcw);
            check({vecs[i].name, "_cycles"}, 32'(dc), 32'(vecs[i].cycles));
            if (vecs[i].cycles != 0) check({vecs[i].name, "_retire"}, 32'(dcw), 32'(vecs[i].last));
        end

        for (int n = 0; n < 40; n++) begin
            op = pool[$urandom_range(13, 0)];
            z  = rnd_bit();
            fw = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(2, 0));
            mw = int'($urandom_range(15, 0));
            build(op, z, fw, mw);
            apply(op, z, trace.size(), dc, dcw);
        end

        // Reset while LW waits in MREAD, then confirm a clean restart from FETCH.
        build(LW, 1'b0, 0, 10);
        apply(LW, 1'b0, 5, dc, dcw);
        do_reset();
        build(RTYPE, 1'b0, 0, 0);
        apply(RTYPE, 1'b0, trace.size(), dc, dcw);
        check("post_reset_add_cycles", 32'(dc), 32'd4);

        // Memory never answers in FETCH: 16 waiting cycles, then ERROR held until reset.
        trace.delete();
        for (int i = 0; i < 16; i++) push(1'b0, fetch_cw(1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(rnd_bit(), '0, i == 0, 1'b0);
        apply(RTYPE, 1'b0, trace.size(), dc, dcw);
        check("watchdog_no_retire", 32'(dc), 32'd0);
        do_reset();
        build(JAL, 1'b0, 0, 0);
        apply(JAL, 1'b0, trace.size(), dc, dcw);
        check("post_error_jal_cycles", 32'(dc), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
